core_data_mem_responder: RTL and testbench
==========================================

# core_data_mem_responder

Responder end of the core's data-memory request/grant/rvalid interface: accepts load/store requests from the memory stage, grants them after a programmable number of wait cycles, performs byte-enabled writes into an internal word array, and returns read data with a one-cycle `data_rvalid_o` pulse. It sits between the core's data port and the platform's data RAM. It serves as the synthesizable data memory and as the bench memory model with controllable grant latency.

## Interface
Parameters:
- `DATA_WIDTH`, 32: data bus width; fixed at 32.
- `MEM_ADDR_DATA_WIDTH`, 12: byte-address width; depth = 2^(MEM_ADDR_DATA_WIDTH-2) words.
- `MEM_TRANSFER_WIDTH`, 4: byte-enable width, one bit per byte lane.
- `GNT_WAIT`, 0: wait cycles before grant, legal range 0..3.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low, on ports `clk` and `rst_n`.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `data_req_i`  in  1  request valid; held until granted.
- `data_wr_i`  in  1  1 = store, 0 = load; qualified by `data_req_i`.
- `data_addr_i`  in  MEM_ADDR_DATA_WIDTH  byte address; word index = `data_addr_i[MSB:2]`; bits [1:0] ignored.
- `data_wdata_i`  in  DATA_WIDTH  store data, lane-aligned.
- `data_be_i`  in  MEM_TRANSFER_WIDTH  byte enables; bit k covers byte lane k, bits [8k+7:8k].
- `data_gnt_o`  out  1  grant; combinational from request and wait counter.
- `data_rvalid_o`  out  1  load data valid, registered.
- `data_rdata_o`  out  DATA_WIDTH  load data, registered; holds its value between loads.

## Operation
- **Wait counter `cnt`** (2 bits):
  - `data_gnt_o = data_req_i & (cnt == GNT_WAIT)`.
  - Each clock, `cnt` increments if `data_req_i & ~data_gnt_o`; otherwise it clears to 0.
- **Implied states:**
  - IDLE: `cnt`=0, no request.
  - WAIT: request pending, `cnt` < GNT_WAIT.
  - GRANT: `data_gnt_o`=1 for exactly one cycle per transfer.
  - GRANT returns to IDLE, or to WAIT if a new request is present next cycle.
- **Granted store** (`data_wr_i`=1): at the grant edge, `mem[idx]` lane k ← `data_wdata_i` lane k for each set `data_be_i[k]`. Unselected lanes are unchanged. `data_be_i`=0 writes nothing. No `data_rvalid_o` is issued for stores.
- **Granted load** (`data_wr_i`=0): at the grant edge, `data_rdata_o` ← `mem[idx]` as a full word (the core extracts bytes). `data_rvalid_o` ← 1.
- **Any other edge:** `data_rvalid_o` ← 0. `data_rdata_o` keeps its value.
- **Abort:** if `data_req_i` drops before grant, `cnt` clears and no access occurs.
- **Ordering:** a store granted at edge N is visible to a load granted at edge N+1 or later. Only one access is granted per cycle, so there is no same-cycle conflict.
- **Memory array:** not reset. Contents are undefined until written; the bench must write before reading.

## Timing
- **Reset values:** `data_rvalid_o`=0, `data_rdata_o`=0, `cnt`=0. `data_gnt_o` follows its equation, so it is 0 while `data_req_i`=0. Reset assertion mid-transfer aborts any pending grant immediately; memory contents are retained.
- **Grant latency:** a request first asserted in cycle T is granted in cycle T+GNT_WAIT. With GNT_WAIT=0, grant is in the same cycle.
- **Load latency:** `data_rvalid_o` and `data_rdata_o` are valid in the cycle after grant, for exactly one cycle.
- **Back-to-back traffic:**
  - With GNT_WAIT=0, a continuously held request is granted every cycle, sustaining one load response per cycle (rvalid stays high).
  - With GNT_WAIT=W>0, consecutive transfers are granted every W+1 cycles, because `cnt` restarts at 0 after each grant.
- **Store completion:** a store completes at the grant edge. The requester may drop `data_req_i` in the following cycle.
- **Input rules:** while `data_req_i`=1 and ungranted, the requester must hold `data_wr_i`, `data_addr_i`, `data_wdata_i` and `data_be_i` stable. Changes are sampled only at the grant edge.

## Test plan
1. **Reset.** Assert `rst_n`=0 mid-wait (GNT_WAIT=2, `cnt`=1) → `data_rvalid_o`=0, `data_rdata_o`=0 and `cnt`=0 asynchronously. After release, the held request is granted 2 cycles later.
2. **Store then load** (GNT_WAIT=0). Store 0xDEADBEEF to address 0x010 with `data_be_i`=4'hF, then load 0x010 → each grant occurs in its request cycle. `data_rvalid_o`=1 with `data_rdata_o`=0xDEADBEEF one cycle after the load grant.
3. **Byte enables.** Word 0x020 holds 0x11223344; store 0xAABBCCDD with `data_be_i`=4'b0101 → a subsequent load returns 0x11BB33DD. A store with `data_be_i`=0 leaves the word unchanged.
4. **Wait states** (GNT_WAIT=3). Request a load at cycle 0 → `data_gnt_o` is 0 in cycles 0–2 and 1 in cycle 3; `data_rvalid_o`=1 in cycle 4 only.
5. **Abort.** With GNT_WAIT=2, assert a store request for 1 cycle, then drop it → no grant and the memory word is unchanged. A re-request then waits the full 2 cycles.
6. **Back-to-back loads** (GNT_WAIT=0). Load addresses 0x000, 0x004 and 0x008 on consecutive cycles → `data_gnt_o` is high 3 cycles and `data_rvalid_o` is high 3 consecutive cycles, returning the three words in order. The stores leave `data_rvalid_o` at 0.

Source files
------------

// File: rtl/core_data_mem_responder_if.sv
// Data-memory request/grant/rvalid bundle between the core's data port and the responder.
// The master modport is the core side; the slave modport is the memory side.
interface core_data_mem_responder_if #(
    parameter int DATA_WIDTH          = 32,
    parameter int MEM_ADDR_DATA_WIDTH = 12,
    parameter int MEM_TRANSFER_WIDTH  = 4
);
    logic                           data_req_i;
    logic                           data_wr_i;
    logic [MEM_ADDR_DATA_WIDTH-1:0] data_addr_i;
    logic [DATA_WIDTH-1:0]          data_wdata_i;
    logic [MEM_TRANSFER_WIDTH-1:0]  data_be_i;
    logic                           data_gnt_o;
    logic                           data_rvalid_o;
    logic [DATA_WIDTH-1:0]          data_rdata_o;

    modport master (
        output data_req_i, data_wr_i, data_addr_i, data_wdata_i, data_be_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o
    );

    modport slave (
        input  data_req_i, data_wr_i, data_addr_i, data_wdata_i, data_be_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o
    );
endinterface

// File: rtl/core_data_mem_responder.sv
// Data-memory responder: grants requests after GNT_WAIT cycles, performs byte-enabled
// stores into a word array and returns load data with a one-cycle rvalid pulse.
module core_data_mem_responder #(
    parameter int DATA_WIDTH          = 32,
    parameter int MEM_ADDR_DATA_WIDTH = 12,
    parameter int MEM_TRANSFER_WIDTH  = 4,
    parameter int GNT_WAIT            = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    core_data_mem_responder_if.slave data_if
);
    localparam int         DEPTH      = 2 ** (MEM_ADDR_DATA_WIDTH - 2);
    localparam logic [1:0] GNT_WAIT_C = 2'(GNT_WAIT);

    logic [1:0]                     cnt_q;
    logic [1:0]                     cnt_d;
    logic                           gnt;
    logic                           wr_en;
    logic                           rd_en;
    logic [MEM_ADDR_DATA_WIDTH-3:0] idx;
    logic                           rvalid_q;
    logic [DATA_WIDTH-1:0]          rdata_q;
    logic [DATA_WIDTH-1:0]          mem_q [DEPTH];
    logic                           unused_addr_lsb;

    assign gnt   = data_if.data_req_i & (cnt_q == GNT_WAIT_C);
    assign cnt_d = (data_if.data_req_i & ~gnt) ? cnt_q + 2'd1 : 2'd0;
    assign idx   = data_if.data_addr_i[MEM_ADDR_DATA_WIDTH-1:2];

    // rst_n gates the store so a reset mid-transfer cannot corrupt retained memory
    assign wr_en = gnt & rst_n & data_if.data_wr_i;
    assign rd_en = gnt & ~data_if.data_wr_i;

    assign unused_addr_lsb = ^data_if.data_addr_i[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Memory is never reset so contents survive a core reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < MEM_TRANSFER_WIDTH; k++) begin
                if (data_if.data_be_i[k]) begin
                    mem_q[idx][8*k +: 8] <= data_if.data_wdata_i[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rd_en;
            if (rd_en) begin
                rdata_q <= mem_q[idx];
            end
        end
    end

    assign data_if.data_gnt_o    = gnt;
    assign data_if.data_rvalid_o = rvalid_q;
    assign data_if.data_rdata_o  = rdata_q;
endmodule

// File: tb/tb_core_data_mem_responder.sv
// Scoreboard bench: three responders with GNT_WAIT 0, 2 and 3 driven by directed
// transfers; load expectations are queued at grant and checked by an rvalid monitor.
`timescale 1ns/1ps
module tb_core_data_mem_responder;
    localparam int AW = 12;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [2:0]         req;
    logic [2:0]         wr;
    logic [2:0][AW-1:0] addr;
    logic [2:0][31:0]   wdata;
    logic [2:0][3:0]    be;
    logic [2:0]         gnt;
    logic [2:0]         rvalid;
    logic [2:0][31:0]   rdata;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            localparam int W = (gi == 0) ? 0 : (gi == 1) ? 2 : 3;
            core_data_mem_responder_if #(
                .DATA_WIDTH(32), .MEM_ADDR_DATA_WIDTH(AW), .MEM_TRANSFER_WIDTH(4)
            ) bus ();
            assign bus.data_req_i   = req[gi];
            assign bus.data_wr_i    = wr[gi];
            assign bus.data_addr_i  = addr[gi];
            assign bus.data_wdata_i = wdata[gi];
            assign bus.data_be_i    = be[gi];
            assign gnt[gi]          = bus.data_gnt_o;
            assign rvalid[gi]       = bus.data_rvalid_o;
            assign rdata[gi]        = bus.data_rdata_o;
            core_data_mem_responder #(
                .DATA_WIDTH(32), .MEM_ADDR_DATA_WIDTH(AW), .MEM_TRANSFER_WIDTH(4), .GNT_WAIT(W)
            ) dut (
                .clk(clk),
                .rst_n(rst_n),
                .data_if(bus)
            );
        end
    endgenerate

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic push_exp(input int i, input logic [31:0] d);
        exp_t e;
        e.data = d;
        e.due  = 32'(cyc + 1);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Called just after a rising edge; returns just after the edge that follows the grant.
    task automatic xfer(input int i, input logic w, input logic [AW-1:0] a,
                        input logic [31:0] d, input logic [3:0] b, input int wait_cyc,
                        input string name);
        $display("xfer %-14s inst=%0d wr=%0b addr=0x%03h data=0x%08h be=%04b wait=%0d",
                 name, i, w, a, d, b, wait_cyc);
        req[i] = 1'b1; wr[i] = w; addr[i] = a; wdata[i] = d; be[i] = b;
        for (int k = 0; k <= wait_cyc; k++) begin
            @(negedge clk);
            check($sformatf("%s gnt cycle %0d", name, k), {31'd0, gnt[i]},
                  (k == wait_cyc) ? 32'd1 : 32'd0);
            if (k == wait_cyc && !w) push_exp(i, d);
            @(posedge clk); #1;
        end
        req[i] = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic have;
        for (int i = 0; i < 3; i++) begin
            if (rvalid[i]) begin
                have = 1'b0;
                e    = '0;
                case (i)
                    0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                    1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                    default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
                endcase
                if (!have) begin
                    check($sformatf("inst%0d unexpected rvalid", i), {31'd0, rvalid[i]}, 32'd0);
                end else begin
                    check($sformatf("inst%0d rdata", i), rdata[i], e.data);
                    check($sformatf("inst%0d rvalid cycle", i), 32'(cyc), e.due);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req = '0; wr = '0; addr = '0; wdata = '0; be = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset inst%0d rvalid", i), {31'd0, rvalid[i]}, 32'd0);
            check($sformatf("reset inst%0d rdata", i), rdata[i], 32'd0);
            check($sformatf("reset inst%0d gnt", i), {31'd0, gnt[i]}, 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Async reset mid-wait on the GNT_WAIT=2 responder
        xfer(1, 1'b1, 12'h060, 32'h5A5A5A5A, 4'hF, 2, "st060");
        xfer(1, 1'b0, 12'h060, 32'h5A5A5A5A, 4'h0, 2, "ld060");
        $display("xfer %-14s inst=1 wr=1 addr=0x030 data=0x12345678 be=1111 reset at cnt=1", "st030_rst");
        req[1] = 1'b1; wr[1] = 1'b1; addr[1] = 12'h030; wdata[1] = 32'h12345678; be[1] = 4'hF;
        @(negedge clk);
        check("rst-test gnt cycle 0", {31'd0, gnt[1]}, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async reset rdata", rdata[1], 32'd0);
        check("async reset rvalid", {31'd0, rvalid[1]}, 32'd0);
        check("async reset gnt", {31'd0, gnt[1]}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        xfer(1, 1'b1, 12'h030, 32'h12345678, 4'hF, 2, "st030_post");
        xfer(1, 1'b0, 12'h030, 32'h12345678, 4'h0, 2, "ld030");

        // Store then load, zero wait
        xfer(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 0, "st010");
        xfer(0, 1'b0, 12'h010, 32'hDEADBEEF, 4'h0, 0, "ld010");

        // Byte enables
        xfer(0, 1'b1, 12'h020, 32'h11223344, 4'hF,    0, "st020_full");
        xfer(0, 1'b1, 12'h020, 32'hAABBCCDD, 4'b0101, 0, "st020_be0101");
        xfer(0, 1'b0, 12'h020, 32'h11BB33DD, 4'h0,    0, "ld020_a");
        xfer(0, 1'b1, 12'h020, 32'hFFFFFFFF, 4'h0,    0, "st020_be0");
        xfer(0, 1'b0, 12'h020, 32'h11BB33DD, 4'h0,    0, "ld020_b");

        // Three wait states
        xfer(2, 1'b1, 12'h040, 32'hCAFEF00D, 4'hF, 3, "st040");
        xfer(2, 1'b0, 12'h040, 32'hCAFEF00D, 4'h0, 3, "ld040");
        @(posedge clk); #1;
        @(negedge clk);
        check("ld040 rvalid drops", {31'd0, rvalid[2]}, 32'd0);
        check("ld040 rdata holds", rdata[2], 32'hCAFEF00D);
        @(posedge clk); #1;

        // Abort before grant
        xfer(1, 1'b1, 12'h050, 32'h0BADF00D, 4'hF, 2, "st050");
        $display("xfer %-14s inst=1 wr=1 addr=0x050 data=0x00000000 be=1111 aborted", "st050_abort");
        req[1] = 1'b1; wr[1] = 1'b1; addr[1] = 12'h050; wdata[1] = 32'h0; be[1] = 4'hF;
        @(negedge clk);
        check("abort gnt cycle 0", {31'd0, gnt[1]}, 32'd0);
        @(posedge clk); #1;
        req[1] = 1'b0;
        @(negedge clk);
        check("abort gnt after drop", {31'd0, gnt[1]}, 32'd0);
        @(posedge clk); #1;
        xfer(1, 1'b0, 12'h050, 32'h0BADF00D, 4'h0, 2, "ld050");

        // Back-to-back stores and loads, zero wait
        xfer(0, 1'b1, 12'h000, 32'hA0A0A0A0, 4'hF, 0, "st000");
        xfer(0, 1'b1, 12'h004, 32'hB1B1B1B1, 4'hF, 0, "st004");
        xfer(0, 1'b1, 12'h008, 32'hC2C2C2C2, 4'hF, 0, "st008");
        xfer(0, 1'b0, 12'h000, 32'hA0A0A0A0, 4'h0, 0, "ld000");
        xfer(0, 1'b0, 12'h004, 32'hB1B1B1B1, 4'h0, 0, "ld004");
        xfer(0, 1'b0, 12'h008, 32'hC2C2C2C2, 4'h0, 0, "ld008");

        repeat (3) @(posedge clk);
        #1;
        check("inst0 responses outstanding", 32'(q0.size()), 32'd0);
        check("inst1 responses outstanding", 32'(q1.size()), 32'd0);
        check("inst2 responses outstanding", 32'(q2.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
